// File: rtl/win_pkg.sv
// rtl/win_pkg.sv - shared types and constants for the 3x3 window serializer
package win_pkg;

  typedef enum logic {
    ACCEPT = 1'b0,
    EMIT   = 1'b1
  } state_e;

  localparam int WIN_TAPS = 9;
  localparam int IDX_W    = 4;

  typedef logic [IDX_W-1:0] idx_t;

  localparam idx_t LAST_IDX = idx_t'(WIN_TAPS - 1);

endpackage

// File: rtl/window_serializer_if.sv
// rtl/window_serializer_if.sv - pixel-in / window-out stream bundle
interface window_serializer_if #(
  parameter int DATA_W = 8
);

  logic              frame_start;
  logic [DATA_W-1:0] pix_in;
  logic              pix_valid;
  logic              pix_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_first;
  logic              out_last;

  modport master (
    output frame_start,
    output pix_in,
    output pix_valid,
    input  pix_ready,
    input  out_data,
    input  out_valid,
    input  out_first,
    input  out_last
  );

  modport slave (
    input  frame_start,
    input  pix_in,
    input  pix_valid,
    output pix_ready,
    output out_data,
    output out_valid,
    output out_first,
    output out_last
  );

endinterface

// File: rtl/line_buffer.sv
// rtl/line_buffer.sv - single-port row store, asynchronous read of the old word, write on the clock edge
module line_buffer #(
  parameter int DEPTH  = 16,
  parameter int DATA_W = 8,
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  // Read returns the pre-write contents, so a same-cycle write never bypasses.
  assign rdata = mem_q[addr];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[addr] <= wdata;
    end
  end

endmodule

// File: rtl/window_serializer.sv
// rtl/window_serializer.sv - buffers two rows and serializes each interior 3x3 window, 9 beats per window
// Optional WIN_CNT_EN adds a 16-bit emitted-window counter output.
module window_serializer #(
  parameter int IMG_WIDTH = 16,
  parameter int DATA_W    = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  window_serializer_if.slave bus
`ifdef WIN_CNT_EN
  ,
  output logic [15:0]        win_cnt
`endif
);

  import win_pkg::*;

  localparam int              COL_W   = $clog2(IMG_WIDTH);
  localparam logic [COL_W-1:0] COL_MAX = COL_W'(IMG_WIDTH - 1);

  state_e            state_q, state_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic [1:0]        row_q, row_d;
  idx_t              idx_q, idx_d;
  logic [DATA_W-1:0] win_q [WIN_TAPS];
  logic [DATA_W-1:0] win_d [WIN_TAPS];

  logic              pix_ready_q, pix_ready_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_valid_q, out_valid_d;
  logic              out_first_q, out_first_d;
  logic              out_last_q, out_last_d;

  logic [DATA_W-1:0] lb_top_rd;
  logic [DATA_W-1:0] lb_mid_rd;
  logic              accept;
  logic              win_ready;

  assign accept    = bus.pix_valid && pix_ready_q && !bus.frame_start;
  assign win_ready = accept && (row_q == 2'd2) && (col_q >= COL_W'(2));

  // Accepting a pixel ages the column: the old middle row moves to the top row.
  line_buffer #(.DEPTH(IMG_WIDTH), .DATA_W(DATA_W)) lb_top (
    .clk   (clk),
    .we    (accept),
    .addr  (col_q),
    .wdata (lb_mid_rd),
    .rdata (lb_top_rd)
  );

  line_buffer #(.DEPTH(IMG_WIDTH), .DATA_W(DATA_W)) lb_mid (
    .clk   (clk),
    .we    (accept),
    .addr  (col_q),
    .wdata (bus.pix_in),
    .rdata (lb_mid_rd)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    col_d   = col_q;
    row_d   = row_q;
    win_d   = win_q;

    if (bus.frame_start) begin
      state_d = ACCEPT;
      idx_d   = '0;
      col_d   = '0;
      row_d   = '0;
    end else begin
      case (state_q)
        ACCEPT: begin
          if (accept) begin
            if (col_q == COL_MAX) begin
              col_d = '0;
              if (row_q != 2'd2) begin
                row_d = row_q + 2'd1;
              end
            end else begin
              col_d = col_q + COL_W'(1);
            end
            // Window is stored row-major: tap r*3+c, row 0 oldest, column 0 leftmost.
            for (int r = 0; r < 3; r++) begin
              win_d[r*3]     = win_q[r*3 + 1];
              win_d[r*3 + 1] = win_q[r*3 + 2];
            end
            win_d[2] = lb_top_rd;
            win_d[5] = lb_mid_rd;
            win_d[8] = bus.pix_in;
            if (win_ready) begin
              state_d = EMIT;
              idx_d   = '0;
            end
          end
        end
        EMIT: begin
          if (idx_q == LAST_IDX) begin
            state_d = ACCEPT;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + idx_t'(1);
          end
        end
        default: begin
          state_d = ACCEPT;
          idx_d   = '0;
        end
      endcase
    end

    // Outputs are registered from the next-state view so the first beat follows the accept by one cycle.
    out_valid_d = (state_d == EMIT);
    out_first_d = out_valid_d && (idx_d == '0);
    out_last_d  = out_valid_d && (idx_d == LAST_IDX);
    out_data_d  = out_valid_d ? win_d[idx_d] : '0;
    pix_ready_d = (state_d == ACCEPT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ACCEPT;
      idx_q       <= '0;
      col_q       <= '0;
      row_q       <= '0;
      pix_ready_q <= 1'b1;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_first_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      col_q       <= col_d;
      row_q       <= row_d;
      pix_ready_q <= pix_ready_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_first_q <= out_first_d;
      out_last_q  <= out_last_d;
    end
  end

  always_ff @(posedge clk) begin
    win_q <= win_d;
  end

  assign bus.pix_ready = pix_ready_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_first = out_first_q;
  assign bus.out_last  = out_last_q;

`ifdef WIN_CNT_EN
  logic [15:0] win_cnt_q, win_cnt_d;

  always_comb begin
    win_cnt_d = win_cnt_q;
    if (bus.frame_start) begin
      win_cnt_d = '0;
    end else if (out_last_q) begin
      win_cnt_d = win_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_cnt_q <= '0;
    end else begin
      win_cnt_q <= win_cnt_d;
    end
  end

  assign win_cnt = win_cnt_q;
`endif

endmodule

// File: tb/tb_window_serializer.sv
// tb/tb_window_serializer.sv - directed/random bench for window_serializer on a 4x4 image
// Define WIN_CNT_EN to also exercise the window counter.
module tb_window_serializer;

  localparam int W = 4;
  localparam int H = 4;
  localparam int NPIX = W * H;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  window_serializer_if #(.DATA_W(8)) bus ();

`ifdef WIN_CNT_EN
  logic [15:0] win_cnt;
`endif

  window_serializer #(.IMG_WIDTH(W), .DATA_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef WIN_CNT_EN
    ,
    .win_cnt (win_cnt)
`endif
  );

  typedef struct {
    logic [7:0] d;
    logic       f;
    logic       l;
    int         cyc;
  } beat_t;

  beat_t      obs[$];
  logic [7:0] exp_q[$];
  logic [7:0] img[NPIX];
  int         acc_cyc[NPIX];
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    assert (got === want)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, want);
    end
  endtask

  always @(negedge clk) begin
    if (bus.out_valid === 1'b1) begin
      obs.push_back('{bus.out_data, bus.out_first, bus.out_last, cyc});
      chk("ready_low_in_burst", {31'd0, bus.pix_ready}, 32'd0);
    end
  end

  // Reference: every interior 3x3 neighbourhood in raster order of its bottom-right pixel.
  function automatic void model();
    for (int r = 2; r < H; r++)
      for (int c = 2; c < W; c++)
        for (int dr = 0; dr < 3; dr++)
          for (int dc = 0; dc < 3; dc++)
            exp_q.push_back(img[(r - 2 + dr) * W + (c - 2 + dc)]);
  endfunction

  function automatic void fill_seq();
    for (int k = 0; k < NPIX; k++) img[k] = 8'(k);
  endfunction

  function automatic void fill_rand();
    for (int k = 0; k < NPIX; k++) img[k] = 8'($urandom_range(255, 1));
  endfunction

  task automatic push(input int k);
    int guard = 0;
    bus.pix_in    = img[k];
    bus.pix_valid = 1'b1;
    while (bus.pix_ready !== 1'b1 && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 40) chk("accept_timeout", {31'd0, bus.pix_ready}, 32'd1);
    acc_cyc[k] = cyc;
    @(negedge clk);
    bus.pix_valid = 1'b0;
  endtask

  task automatic send_frame(input int gap_max);
    for (int k = 0; k < NPIX; k++) begin
      if (gap_max > 0) repeat ($urandom_range(gap_max, 0)) @(negedge clk);
      push(k);
    end
  endtask

  task automatic start_frame();
    bus.frame_start = 1'b1;
    @(negedge clk);
    bus.frame_start = 1'b0;
  endtask

  task automatic check_bursts(input string tag);
    int n;
    chk({tag, "_beats"}, obs.size(), exp_q.size());
    n = (obs.size() < exp_q.size()) ? obs.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      chk({tag, "_data"}, {24'd0, obs[i].d}, {24'd0, exp_q[i]});
      chk({tag, "_first"}, {31'd0, obs[i].f}, {31'd0, (i % 9) == 0});
      chk({tag, "_last"}, {31'd0, obs[i].l}, {31'd0, (i % 9) == 8});
    end
    obs.delete();
    exp_q.delete();
  endtask

  initial begin
    int t;
    bus.frame_start = 1'b0;
    bus.pix_valid   = 1'b0;
    bus.pix_in      = '0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_out_data", {24'd0, bus.out_data}, 32'd0);
    chk("rst_out_first", {31'd0, bus.out_first}, 32'd0);
    chk("rst_out_last", {31'd0, bus.out_last}, 32'd0);
`ifdef WIN_CNT_EN
    chk("rst_win_cnt", {16'd0, win_cnt}, 32'd0);
`endif
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_pix_ready", {31'd0, bus.pix_ready}, 32'd1);

    // Sequential frame, valid held high: contents plus latency
    start_frame();
    fill_seq();
    model();
    send_frame(0);
    repeat (14) @(negedge clk);
    t = acc_cyc[10];
    chk("lat_first_beat", obs[0].cyc, t + 1);
    chk("lat_last_beat", obs[8].cyc, t + 9);
    chk("lat_next_accept", acc_cyc[11], t + 10);
    check_bursts("seq");
`ifdef WIN_CNT_EN
    chk("win_cnt_frame", {16'd0, win_cnt}, 32'd4);
    start_frame();
    chk("win_cnt_cleared", {16'd0, win_cnt}, 32'd0);
`endif

    // Same frame with random gaps
    start_frame();
    fill_seq();
    model();
    send_frame(3);
    repeat (14) @(negedge clk);
    check_bursts("seq_gapped");

    // Random pixel values with random gaps
    for (int f = 0; f < 3; f++) begin
      start_frame();
      fill_rand();
      model();
      send_frame(f + 1);
      repeat (14) @(negedge clk);
      check_bursts("rand_gapped");
    end

    // frame_start while burst 2 is at idx 4
    start_frame();
    fill_seq();
    for (int k = 0; k < 12; k++) push(k);
    repeat (4) @(negedge clk);
    chk("abort_mid_valid", {31'd0, bus.out_valid}, 32'd1);
    chk("abort_mid_data", {24'd0, bus.out_data}, 32'd6);
    bus.frame_start = 1'b1;
    bus.pix_valid   = 1'b1;
    bus.pix_in      = 8'hEE;
    @(negedge clk);
    bus.frame_start = 1'b0;
    bus.pix_valid   = 1'b0;
    chk("abort_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("abort_out_first", {31'd0, bus.out_first}, 32'd0);
    chk("abort_out_last", {31'd0, bus.out_last}, 32'd0);
    chk("abort_pix_ready", {31'd0, bus.pix_ready}, 32'd1);
    @(negedge clk);
    obs.delete();
    exp_q.delete();
    fill_seq();
    model();
    send_frame(2);
    repeat (14) @(negedge clk);
    check_bursts("after_abort");

    // Asynchronous reset in the middle of a burst
    start_frame();
    fill_rand();
    for (int k = 0; k < 11; k++) push(k);
    repeat (3) @(negedge clk);
    chk("pre_reset_valid", {31'd0, bus.out_valid}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("async_rst_data", {24'd0, bus.out_data}, 32'd0);
    chk("async_rst_last", {31'd0, bus.out_last}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", {31'd0, bus.pix_ready}, 32'd1);
    chk("post_rst_valid", {31'd0, bus.out_valid}, 32'd0);
    obs.delete();
    exp_q.delete();
    fill_rand();
    model();
    send_frame(1);
    repeat (14) @(negedge clk);
    check_bursts("after_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
